// File: rtl/kt_pkg.sv
// Shared constants and types for the Knight's Tour command sequencer.
package kt_pkg;

  // Command opcodes
  localparam logic [3:0] MOVE    = 4'h4;  // plain move, used for the vertical leg
  localparam logic [3:0] MOVE_FF = 4'h5;  // move with fanfare, used for the horizontal leg

  // Headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes
  localparam logic [7:0] RESP_DONE = 8'hA5;  // idle / final move of a tour
  localparam logic [7:0] RESP_ACK  = 8'h5A;  // intermediate tour acknowledge

  // Bit positions of the one-hot knight move
  typedef enum logic [2:0] {
    MV_B0,  // (+1,+2)
    MV_B1,  // (-1,+2)
    MV_B2,  // (-2,+1)
    MV_B3,  // (-2,-1)
    MV_B4,  // (-1,-2)
    MV_B5,  // (+1,-2)
    MV_B6,  // (+2,-1)
    MV_B7   // (+2,+1)
  } move_bit_e;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_e;

  function automatic logic [15:0] make_cmd(logic [3:0] opcode, logic [7:0] heading,
                                           logic [3:0] squares);
    return {opcode, heading, squares};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal move command.
module knight_move_decode
  import kt_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  move_bit_e        sel;
  logic signed [2:0] dx;
  logic signed [2:0] dy;
  logic [2:0]        adx;
  logic [2:0]        ady;

  assign valid = |move;

  // Pick the lowest set bit so a multi-hot move still yields one legal move.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = MV_B0;
    for (int i = 7; i >= 0; i--) begin
      if (move[i]) sel = move_bit_e'(i[2:0]);
    end
  end

  // Board displacement of the selected move, then sign/magnitude per axis.
  always_comb begin
    dx = 3'sd0;
    dy = 3'sd0;
    case (sel)
      MV_B0: begin dx =  3'sd1; dy =  3'sd2; end
      MV_B1: begin dx = -3'sd1; dy =  3'sd2; end
      MV_B2: begin dx = -3'sd2; dy =  3'sd1; end
      MV_B3: begin dx = -3'sd2; dy = -3'sd1; end
      MV_B4: begin dx = -3'sd1; dy = -3'sd2; end
      MV_B5: begin dx =  3'sd1; dy = -3'sd2; end
      MV_B6: begin dx =  3'sd2; dy = -3'sd1; end
      MV_B7: begin dx =  3'sd2; dy =  3'sd1; end
      default: begin dx = 3'sd0; dy = 3'sd0; end
    endcase
    adx = dx[2] ? 3'(-dx) : 3'(dx);
    ady = dy[2] ? 3'(-dy) : 3'(dy);
    vert_cmd = make_cmd(MOVE,    dy[2] ? HDG_S : HDG_N, {1'b0, ady});
    horz_cmd = make_cmd(MOVE_FF, dx[2] ? HDG_W : HDG_E, {1'b0, adx});
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Command sequencer/arbiter between the UART command path and cmd_proc.
// Passes UART commands through while idle; during a tour it owns cmd_proc and
// issues each knight move as a vertical leg followed by a horizontal leg.
module tour_cmd_seq
  import kt_pkg::*;
#(
  parameter int TOUR_LEN = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_active
);

  localparam logic [4:0] LAST_IDX = 5'(TOUR_LEN - 1);

  state_e      state;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        move_ok;
  logic        last_move;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .valid    (move_ok)
  );

  assign last_move = (mv_indx == LAST_IDX);

  // Tour FSM; resp and tour_active are registered alongside the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mv_indx     <= '0;
      resp        <= RESP_DONE;
      tour_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_tour) begin
            state       <= VERT;
            mv_indx     <= '0;
            resp        <= RESP_ACK;
            tour_active <= 1'b1;
          end
        end
        VERT: begin
          // An empty move means the solver has nothing more: abandon the tour.
          if (!move_ok) begin
            state       <= IDLE;
            resp        <= RESP_DONE;
            tour_active <= 1'b0;
          end else if (clr_cmd_rdy) begin
            state <= WAIT_V;
          end
        end
        WAIT_V: begin
          if (send_resp) state <= HORZ;
        end
        HORZ: begin
          if (!move_ok) begin
            state       <= IDLE;
            resp        <= RESP_DONE;
            tour_active <= 1'b0;
          end else if (clr_cmd_rdy) begin
            state <= WAIT_H;
            if (last_move) resp <= RESP_DONE;
          end
        end
        WAIT_H: begin
          if (send_resp) begin
            if (last_move) begin
              state       <= IDLE;
              resp        <= RESP_DONE;
              tour_active <= 1'b0;
            end else begin
              state   <= VERT;
              mv_indx <= mv_indx + 5'd1;
              resp    <= RESP_ACK;
            end
          end
        end
        default: begin
          state       <= IDLE;
          resp        <= RESP_DONE;
          tour_active <= 1'b0;
        end
      endcase
    end
  end

  // Command mux: UART pass-through in IDLE, tour legs otherwise; UART is never
  // forwarded nor cleared while a tour owns the interface.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = move_ok;
      end
      WAIT_V: cmd = vert_cmd;
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = move_ok;
      end
      WAIT_H: cmd = horz_cmd;
      default: begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Command sequencer and arbiter sitting between the UART command path and `cmd_proc` in `KnightsTour`. In idle it passes UART commands straight through. When a tour is started it takes ownership of the `cmd_proc` command interface. It walks the solved move list from the tour solver, splitting each knight move into a vertical leg followed by a horizontal leg, and issues each leg as a 16-bit move command.

## Interface
Parameters:
- `TOUR_LEN`, default 24: number of moves in a tour (5x5 board).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_tour` in 1: one-cycle pulse from the solver; the solution is ready.
- `move` in 8: one-hot knight move at `mv_indx`, combinational read.
- `mv_indx` out 5: index of the current move.
- `cmd_UART` in 16: command from UART wrapper.
- `cmd_rdy_UART` in 1: UART command valid.
- `clr_cmd_rdy_UART` out 1: consume the UART command.
- `cmd` out 16: command to `cmd_proc`.
- `cmd_rdy` out 1: `cmd` valid.
- `clr_cmd_rdy` in 1: `cmd_proc` has accepted `cmd`.
- `send_resp` in 1: `cmd_proc` has finished a command.
- `resp` out 8: response byte to UART.
- `tour_active` out 1: high whenever the FSM is not in IDLE.

## Operation
- Command format: `[15:12]` opcode, `[11:4]` heading, `[3:0]` squares.
  - Vertical leg: opcode 4'h4 (move).
  - Horizontal leg: opcode 4'h5 (move with fanfare).
- Headings:
  - N = 8'h00.
  - S = 8'h7F.
  - W = 8'h3F.
  - E = 8'hBF.
- Move bits, as (dx,dy):
  - b0 (+1,+2)
  - b1 (-1,+2)
  - b2 (-2,+1)
  - b3 (-2,-1)
  - b4 (-1,-2)
  - b5 (+1,-2)
  - b6 (+2,-1)
  - b7 (+2,+1)
- Leg decoding: vertical leg = sign(dy), |dy|; horizontal leg = sign(dx), |dx|.
  - Example, b0: 16'h4002 then 16'h5BF1.
  - Example, b3: 16'h47F1 then 16'h53F2.
- Multi-hot `move`: the lowest set bit wins.
- `move`==0: the tour aborts to IDLE; no command is issued.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`. On `start_tour`: `mv_indx`←0, go to VERT.
  - VERT: `cmd`=vertical leg, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: `cmd_rdy`=0. On `send_resp`, go to HORZ.
  - HORZ: `cmd`=horizontal leg, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: on `send_resp`:
    - if `mv_indx`==`TOUR_LEN`-1, go to IDLE;
    - else `mv_indx`+1, go to VERT.
- Responses:
  - `resp`=8'hA5 in IDLE.
  - `resp`=8'hA5 in WAIT_H when on the last move.
  - `resp`=8'h5A otherwise (intermediate tour ack).
- `cmd_rdy_UART` during a tour is ignored: not forwarded and not cleared.
- `start_tour` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `mv_indx`=0.
  - `cmd_rdy`=`cmd_rdy_UART` (pass-through).
  - `tour_active`=0.
  - `resp`=8'hA5.
- Reset mid-tour: returns to IDLE immediately (asynchronous). No command is left pending.
- `cmd`, `cmd_rdy` and `clr_cmd_rdy_UART` are combinational from state, `move` and the UART inputs. No added latency in pass-through.
- `start_tour`→`cmd_rdy` high: 1 cycle.
- `clr_cmd_rdy` and `send_resp` are sampled on the rising edge.
  - `send_resp` in VERT or HORZ is ignored.
  - `clr_cmd_rdy` and `send_resp` arriving in the same cycle in VERT: take the `clr` transition only.
- `mv_indx` changes only on the WAIT_H→VERT edge. `move` must be valid combinationally in the same cycle.
- `mv_indx` never exceeds `TOUR_LEN`-1; no wrap-around.

## Structure
- `kt_pkg` holds:
  - opcode constants `MOVE`/`MOVE_FF`;
  - heading constants N/S/E/W;
  - move-bit enum;
  - FSM state enum.
- Sub-module `knight_move_decode`: purely combinational, `move[7:0]` → `vert_cmd[15:0]`, `horz_cmd[15:0]`, `valid`.

## Test plan
- Pass-through: in IDLE, `cmd_UART`=16'h2000 with `cmd_rdy_UART`=1 → `cmd`=16'h2000 and `cmd_rdy`=1 the same cycle; `clr_cmd_rdy` pulse → `clr_cmd_rdy_UART` pulse.
- Single move b0 with `TOUR_LEN`=1:
  - `start_tour` → `cmd`=16'h4002 / `cmd_rdy`; then `clr` + `send_resp`.
  - Then `cmd`=16'h5BF1; then `send_resp` with `resp`=8'hA5.
  - FSM returns to IDLE.
- Move b3 → 16'h47F1 then 16'h53F2; the intermediate `resp`=8'h5A.
- Full 24-move tour, moves cycling b0..b7:
  - 48 commands issued in order;
  - `mv_indx` ends at 23;
  - exactly one 8'hA5 response, at the end.
- Tour interference: `cmd_rdy_UART`=1 and `start_tour` pulsed during WAIT_V → `cmd` and `clr_cmd_rdy_UART` are unaffected, and the tour continues.
- Reset mid-tour: `rst_n` low in HORZ at `mv_indx`=7 → IDLE, `mv_indx`=0, `tour_active`=0 immediately.
- Abort: `move`=0 at `mv_indx`=3 → IDLE with no VERT command issued.
